// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared width, increment and state encoding for the fetch sequencer
package fetch_sequencer_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int INCR = 1;
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2,
    FS_ADV  = 2'd3
  } fs_state_t;
endpackage

// File: rtl/fetch_sequencer_branch_latch.sv
// branch_latch: pending-branch flag and offset, newest pulse overwrites, consumed by the IP update
module branch_latch #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pulse,
  input  logic [WORD_WIDTH-1:0] offset_in,
  input  logic                  consume,
  output logic                  pending,
  output logic [WORD_WIDTH-1:0] offset
);
  // a pulse landing on the consuming cycle is applied immediately, so consume wins
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending <= 1'b0;
      offset  <= '0;
    end else if (consume) begin
      pending <= 1'b0;
    end else if (pulse) begin
      pending <= 1'b1;
      offset  <= offset_in;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: walks the IP through request, hold-for-decode and update, with branch redirect
module fetch_sequencer #(
  parameter int WORD_WIDTH = fetch_sequencer_pkg::WORD_WIDTH,
  parameter int INCR       = fetch_sequencer_pkg::INCR
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] ip,
  output logic [WORD_WIDTH-1:0] ip_adj,
  output logic                  ip_update,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [WORD_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  branch_valid,
  input  logic [WORD_WIDTH-1:0] branch_offset,
  input  logic                  halt
);
  import fetch_sequencer_pkg::*;
  fs_state_t st, nxt;
  logic to_adv, mem_req_d, instr_valid_d, pending;
  logic [WORD_WIDTH-1:0] mem_addr_d, instr_d, pend_off, adj;
  branch_latch #(.WORD_WIDTH(WORD_WIDTH)) u_branch (
    .clk(clk),
    .reset_n(reset_n),
    .pulse(branch_valid),
    .offset_in(branch_offset),
    .consume(to_adv),
    .pending(pending),
    .offset(pend_off)
  );
  // a branch arriving on the same cycle we head into ADV takes priority over any older pending one
  assign adj = branch_valid ? branch_offset : pending ? pend_off : WORD_WIDTH'(INCR);
  // state and all outputs are registered so decode and memory see glitch-free signals
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st          <= FS_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      ip_update   <= 1'b0;
      ip_adj      <= '0;
    end else begin
      st          <= nxt;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      ip_update   <= to_adv;
      ip_adj      <= to_adv ? adj : '0;
    end
  // next state; leaving ADV the fetch address is the IP the register is about to take on
  always_comb begin
    nxt           = st;
    to_adv        = 1'b0;
    mem_req_d     = mem_req;
    mem_addr_d    = mem_addr;
    instr_d       = instr;
    instr_valid_d = instr_valid;
    case (st)
      FS_IDLE: if (!halt) begin
        nxt        = FS_REQ;
        mem_req_d  = 1'b1;
        mem_addr_d = ip;
      end
      FS_REQ: if (branch_valid) begin
        nxt       = FS_ADV;
        to_adv    = 1'b1;
        mem_req_d = 1'b0;
      end else if (mem_ack) begin
        nxt           = FS_HOLD;
        mem_req_d     = 1'b0;
        instr_d       = mem_data;
        instr_valid_d = 1'b1;
      end
      FS_HOLD: if (branch_valid || instr_ready) begin
        nxt           = FS_ADV;
        to_adv        = 1'b1;
        instr_valid_d = 1'b0;
      end
      default: begin
        nxt        = halt ? FS_IDLE : FS_REQ;
        mem_req_d  = !halt;
        mem_addr_d = halt ? mem_addr : ip + ip_adj;
      end
    endcase
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench acting as IP register, memory and decode
module tb_fetch_sequencer;
  localparam int W = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [W-1:0] ip, ip_adj, mem_addr, mem_data, instr, branch_offset;
  logic ip_update, mem_req, mem_ack, instr_valid, instr_ready, branch_valid, halt;
  int compared = 0, mismatched = 0;
  logic [W-1:0] aq[$], iq[$], jq[$];

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .ip(ip), .ip_adj(ip_adj), .ip_update(ip_update),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_offset(branch_offset), .halt(halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) ip <= '0;
    else if (ip_update) ip <= ip + ip_adj;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] j, input bit deliver);
    aq.push_back(a);
    jq.push_back(j);
    if (deliver) iq.push_back(16'h1000 + a);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
    chk("req_timeout", W'(mem_req), 16'd1);
  endtask

  task automatic ack();
    chk("mem_addr", mem_addr, aq.pop_front());
    mem_ack = 1'b1;
    mem_data = 16'h1000 + mem_addr;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("valid_rise", W'(instr_valid), 16'd1);
    chk("req_drop", W'(mem_req), 16'd0);
    chk("instr", instr, iq.pop_front());
  endtask

  task automatic accept(input int stall, input bit adv_branch);
    logic [W-1:0] held;
    held = instr;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", W'(instr_valid), 16'd1);
      chk("hold_instr", instr, held);
      chk("hold_no_update", W'(ip_update), 16'd0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("adv_update", W'(ip_update), 16'd1);
    chk("adv_valid_drop", W'(instr_valid), 16'd0);
    chk("ip_adj", ip_adj, jq.pop_front());
    if (adv_branch) begin
      branch_valid = 1'b1;
      branch_offset = 16'h0040;
    end
    @(negedge clk);
    branch_valid = 1'b0;
    chk("update_once", W'(ip_update), 16'd0);
    chk("adj_zero", ip_adj, 16'd0);
  endtask

  initial begin
    mem_ack = 0; mem_data = '0; instr_ready = 0; branch_valid = 0; branch_offset = '0; halt = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", W'(mem_req), 16'd0);
    chk("rst_valid", W'(instr_valid), 16'd0);
    chk("rst_update", W'(ip_update), 16'd0);
    chk("rst_adj", ip_adj, 16'd0);
    chk("rst_instr", instr, 16'd0);
    chk("rst_addr", mem_addr, 16'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(W'(k), 16'd1, 1);
      wait_req();
      ack();
      accept(0, 0);
    end
    push(16'd4, 16'hFFFE, 1);
    wait_req();
    ack();
    branch_valid = 1'b1;
    branch_offset = 16'hFFFE;
    @(negedge clk);
    branch_valid = 1'b0;
    chk("hold_squash_valid", W'(instr_valid), 16'd0);
    chk("hold_squash_update", W'(ip_update), 16'd1);
    chk("hold_squash_adj", ip_adj, jq.pop_front());
    @(negedge clk);
    chk("hold_squash_once", W'(ip_update), 16'd0);
    push(16'd2, 16'd1, 1);
    wait_req();
    ack();
    accept(5, 0);
    push(16'd3, 16'd8, 0);
    wait_req();
    chk("race_addr", mem_addr, aq.pop_front());
    mem_ack = 1'b1;
    mem_data = 16'hDEAD;
    branch_valid = 1'b1;
    branch_offset = 16'd8;
    @(negedge clk);
    mem_ack = 1'b0;
    branch_valid = 1'b0;
    chk("race_discard", W'(instr_valid), 16'd0);
    chk("race_req_drop", W'(mem_req), 16'd0);
    chk("race_update", W'(ip_update), 16'd1);
    chk("race_adj", ip_adj, jq.pop_front());
    @(negedge clk);
    chk("race_still_discard", W'(instr_valid), 16'd0);
    chk("race_once", W'(ip_update), 16'd0);
    push(16'd11, 16'd1, 1);
    wait_req();
    ack();
    accept(0, 0);
    push(16'd12, 16'd1, 1);
    wait_req();
    halt = 1'b1;
    ack();
    accept(0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("halt_idle_req", W'(mem_req), 16'd0);
      chk("halt_idle_update", W'(ip_update), 16'd0);
      @(negedge clk);
    end
    halt = 1'b0;
    push(16'd13, 16'd1, 1);
    wait_req();
    ack();
    accept(0, 1);
    wait_req();
    chk("pre_reset_addr", mem_addr, 16'd14);
    #3 reset_n = 1'b0;
    #1;
    chk("async_req", W'(mem_req), 16'd0);
    chk("async_valid", W'(instr_valid), 16'd0);
    chk("async_update", W'(ip_update), 16'd0);
    chk("async_addr", mem_addr, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    push(16'd0, 16'd1, 1);
    wait_req();
    ack();
    accept(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
